cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
// - Line-refill engine directly downstream of the direct-mapped cache on the miss path.
// - Accepts one miss address and issues a single burst read to memory.
// - Collects the returned line beats and writes each word into the cache data array.
// - Then commits tag/valid for that set, so the cache reports a hit on the retried access.
// PARAMETERS
// - ADDRESS_WIDTH  32  byte-address width
// - BLOCK_SIZE     64  line size in bytes
// - NUM_SETS       16  sets in cache (direct-mapped)
// - DATA_WIDTH     32  memory/cache word width in bits
// - Derived localparams:
//   - WORDS = BLOCK_SIZE*8/DATA_WIDTH (16)
//   - WB = $clog2(DATA_WIDTH/8)
//   - OFFSET_BITS = $clog2(BLOCK_SIZE)
//   - INDEX_BITS = $clog2(NUM_SETS)
//   - TAG_BITS = ADDRESS_WIDTH-OFFSET_BITS-INDEX_BITS
// PORTS
// - clk          in   1              single clock, all logic posedge
// - rst_n        in   1              reset, asynchronous assert, active-low
// - miss_valid   in   1              cache presents a miss
// - miss_addr    in   ADDRESS_WIDTH  missing byte address
// - miss_ready   out  1              engine idle, miss accepted when valid&ready
// - mem_req      out  1              burst read request
// - mem_addr     out  ADDRESS_WIDTH  burst start address, stable while mem_req=1
// - mem_gnt      in   1              memory accepts request
// - mem_rvalid   in   1              one data beat valid this cycle
// - mem_rdata    in   DATA_WIDTH     beat data
// - fill_we      out  1              write one word into cache data array
// - fill_index   out  INDEX_BITS     set being filled
// - fill_word    out  $clog2(WORDS)  word slot within line
// - fill_data    out  DATA_WIDTH     word to write
// - fill_done    out  1              1-cycle pulse: set tags[fill_index]=fill_tag, valid=1
// - fill_tag     out  TAG_BITS       tag to commit
// - crit_valid   out  1              critical-word forward pulse (feature only)
// - crit_data    out  DATA_WIDTH     critical word (feature only)
// BEHAVIOUR
// - Reset: state=IDLE. miss_ready=1. All other outputs are 0, including fill_index, fill_word,
//   fill_tag, mem_addr, crit_data, and the beat counter.
// - FSM IDLE->REQ->BEAT->DONE->IDLE. All outputs are registered.
//   - IDLE: miss_ready=1. On miss_valid, latch tag/index/word offset; next state REQ.
//   - REQ: mem_req=1, mem_addr held. When mem_gnt=1, next state BEAT and mem_req drops next cycle.
//     Gnt may arrive in the first REQ cycle.
//   - BEAT: each mem_rvalid -> next cycle fill_we=1, fill_data=mem_rdata, fill_word=current slot.
//     The counter then increments. rvalid gaps are allowed; fill_we=0 in gap cycles.
//     After the WORDS-th beat, next state DONE.
//   - DONE: fill_done=1 for exactly 1 cycle, coinciding with the last fill_we cycle +1. Next state IDLE.
// - miss_ready=0 in REQ/BEAT/DONE. A miss_valid in those states is not accepted;
//   the requester must hold it.
// - Back-to-back: a miss presented in the IDLE cycle following DONE is accepted.
//   Minimum turnaround is 1 cycle of miss_ready=1.
// - mem_rvalid outside BEAT is ignored.
// - mem_gnt outside REQ is ignored.
// - Slot counter is $clog2(WORDS) bits and wraps modulo WORDS.
// - Latency, gnt immediate, rvalid every cycle: accept→mem_req 1 clk; first fill_we 3 clk after accept;
//   fill_done WORDS+3 clk after accept.
// - rst_n low mid-burst: immediate return to IDLE, all outputs 0/miss_ready=1.
//   No fill_done is produced and the partial line is left invalid.
// CONFIGURATION
// - CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined:
//   - mem_addr = miss_addr with low WB bits zeroed.
//   - Beats fill slots starting at the missed word and wrap modulo WORDS (wrapping burst).
//   - With the first fill_we, crit_valid=1 for 1 cycle and crit_data=first beat.
// - Undefined:
//   - mem_addr = line base, with low OFFSET_BITS zeroed.
//   - Slots fill 0..WORDS-1.
//   - crit_valid and crit_data are tied 0.
// TESTING
// 1. Reset: assert rst_n=0 mid-run -> miss_ready=1, mem_req=0, fill_we=0, fill_done=0 in the same cycle.
// 2. Basic refill, no macro: miss_addr=0x0000_1A48, gnt immediate, beats 0x100..0x10F ->
//    - mem_addr=0x0000_1A40.
//    - 16 fill_we, index=9, words 0..15, data 0x100..0x10F.
//    - fill_done with fill_tag=6.
// 3. Stalls: gnt after 5 REQ cycles and rvalid every other cycle ->
//    - mem_addr stable throughout REQ.
//    - Exactly 16 fill_we, fill_done once.
//    - miss_ready=0 until the cycle after fill_done.
// 4. Busy: miss_valid held with addr 0x2000 during a refill -> not accepted until IDLE.
//    The next refill then starts with mem_addr=0x2000.
// 5. With macro: miss_addr=0x0000_1A48 ->
//    - mem_addr=0x0000_1A48.
//    - fill_word order 2,3..15,0,1.
//    - crit_valid on the first fill with crit_data=first beat.
// 6. Reset on beat 7 of 16 -> no fill_done. A new miss after reset is serviced normally.

Source files
------------

// File: rtl/cache_refill_if.sv
// Signal bundle between the miss path, the memory port and the cache fill port.
// The refill engine connects through the slave modport; the cache/memory side uses master.
interface cache_refill_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 64,
  parameter int NUM_SETS      = 16,
  parameter int DATA_WIDTH    = 32
);
  localparam int WORDS       = BLOCK_SIZE * 8 / DATA_WIDTH;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = ADDRESS_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int SLOT_BITS   = $clog2(WORDS);

  logic                     miss_valid;
  logic [ADDRESS_WIDTH-1:0] miss_addr;
  logic                     miss_ready;
  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_gnt;
  logic                     mem_rvalid;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     fill_we;
  logic [INDEX_BITS-1:0]    fill_index;
  logic [SLOT_BITS-1:0]     fill_word;
  logic [DATA_WIDTH-1:0]    fill_data;
  logic                     fill_done;
  logic [TAG_BITS-1:0]      fill_tag;
  logic                     crit_valid;
  logic [DATA_WIDTH-1:0]    crit_data;

  modport slave (
    input  miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_we, fill_index, fill_word, fill_data,
           fill_done, fill_tag, crit_valid, crit_data
  );

  modport master (
    output miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_we, fill_index, fill_word, fill_data,
           fill_done, fill_tag, crit_valid, crit_data
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: one burst read per miss, word-by-word fill, then tag/valid commit.
// Define CACHE_REFILL_CRITICAL_WORD_FIRST_EN for a wrapping burst starting at the missed word.
//
// state | meaning
// IDLE  | miss_ready=1, waiting for a miss
// REQ   | mem_req held until mem_gnt
// BEAT  | collecting WORDS beats, one fill_we per beat
// DONE  | fill_done pulse, tag/valid commit
module cache_refill_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 64,
  parameter int NUM_SETS      = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cache_refill_if.slave bus
);
  localparam int WORDS       = BLOCK_SIZE * 8 / DATA_WIDTH;
  localparam int WB          = $clog2(DATA_WIDTH / 8);
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = ADDRESS_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int SLOT_BITS   = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, BEAT = 2'd2, DONE = 2'd3} state_t;

  state_t                   state, state_nxt;
  logic                     miss_ready_q, mem_req_q, fill_we_q, fill_done_q, last_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [INDEX_BITS-1:0]    index_q;
  logic [TAG_BITS-1:0]      tag_q;
  logic [SLOT_BITS-1:0]     slot_q, start_q, start_nxt, fill_word_q;
  logic [DATA_WIDTH-1:0]    fill_data_q;
  logic                     accept, beat, last_beat;

  assign accept    = (state == IDLE) && bus.miss_valid;
  // last_q masks any rvalid in the BEAT cycle that follows the final beat
  assign beat      = (state == BEAT) && bus.mem_rvalid && !last_q;
  assign last_beat = beat && ((slot_q + SLOT_BITS'(1)) == start_q);

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_nxt    = bus.miss_addr[OFFSET_BITS-1:WB];
  assign mem_addr_nxt = {bus.miss_addr[ADDRESS_WIDTH-1:WB], {WB{1'b0}}};
`else
  assign start_nxt    = '0;
  assign mem_addr_nxt = {bus.miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.miss_valid) state_nxt = REQ;
      REQ:     if (bus.mem_gnt)    state_nxt = BEAT;
      BEAT:    if (last_q)         state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      fill_we_q    <= 1'b0;
      fill_done_q  <= 1'b0;
      last_q       <= 1'b0;
      mem_addr_q   <= '0;
      index_q      <= '0;
      tag_q        <= '0;
      slot_q       <= '0;
      start_q      <= '0;
      fill_word_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      miss_ready_q <= (state_nxt == IDLE);
      mem_req_q    <= (state_nxt == REQ);
      fill_done_q  <= (state_nxt == DONE);
      fill_we_q    <= beat;
      if (accept) begin
        tag_q      <= bus.miss_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
        index_q    <= bus.miss_addr[OFFSET_BITS +: INDEX_BITS];
        start_q    <= start_nxt;
        slot_q     <= start_nxt;
        mem_addr_q <= mem_addr_nxt;
        last_q     <= 1'b0;
      end
      if (beat) begin
        fill_word_q <= slot_q;
        fill_data_q <= bus.mem_rdata;
        slot_q      <= slot_q + SLOT_BITS'(1);
        if (last_beat) last_q <= 1'b1;
      end
    end
  end

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic                  crit_valid_q;
  logic [DATA_WIDTH-1:0] crit_data_q;

  // the slot equals the start word only on the first beat of a wrapping burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= beat && (slot_q == start_q);
      if (beat && (slot_q == start_q)) crit_data_q <= bus.mem_rdata;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

  assign bus.miss_ready = miss_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_we    = fill_we_q;
  assign bus.fill_index = index_q;
  assign bus.fill_word  = fill_word_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.fill_done  = fill_done_q;
  assign bus.fill_tag   = tag_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed vector table, reset/busy sequences, random refills
// checked against an address-arithmetic model of the expected burst and fill stream.
module tb_cache_refill_ctrl;
  localparam int BS    = 64;
  localparam int NS    = 16;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  cache_refill_if bus ();
  cache_refill_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          gnt_dly;
    int          gap;
    logic [31:0] base;
    logic [31:0] exp_maddr;
    int          exp_idx;
    int          exp_tag;
    int          exp_first;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input int gnt_dly, input logic [31:0] base);
    vec_t v;
    v.addr    = a;
    v.gnt_dly = gnt_dly;
    v.gap     = -1;
    v.base    = base;
    v.exp_idx = int'((a / BS) % NS);
    v.exp_tag = int'(a / (BS * NS));
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    v.exp_maddr = a - (a % 4);
    v.exp_first = int'((a % BS) / 4);
`else
    v.exp_maddr = a - (a % BS);
    v.exp_first = 0;
`endif
    return v;
  endfunction

  // Drives one refill from acceptance to the return of miss_ready and checks it.
  // abort>0 pulls rst_n low once that many fills have been seen.
  task automatic run_refill(input vec_t v, input bit junk, input bit lat, input bit hold,
                            input logic [31:0] hold_addr, input int abort);
    int k, req_cyc, req_rise, beats, done_cnt, done_k, last_fill_k, first_fill_k;
    int ready_k, crit_cnt, crit_k, first_req_k, addr_chg, grant_k, ph, lat_err;
    logic [31:0] addr_seen, crit_d;
    logic [21:0] done_tag;
    logic [3:0]  done_idx;
    logic        granted, prev_req;
    logic [63:0] fq[$];
    int          beat_k[$];
    req_cyc = 0; req_rise = 0; beats = 0; done_cnt = 0; done_k = -1; last_fill_k = -1;
    first_fill_k = -1; ready_k = -1; crit_cnt = 0; crit_k = -1; first_req_k = -1;
    addr_chg = 0; grant_k = 0; ph = 0; lat_err = 0; addr_seen = '0; crit_d = '0;
    done_tag = '0; done_idx = '0; granted = 1'b0; prev_req = 1'b0;

    bus.miss_valid = 1'b1;
    bus.miss_addr  = v.addr;
    k = 0;
    while (!bus.miss_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("miss_accepted", bus.miss_ready, 1);
    if (!bus.miss_ready) begin
      bus.miss_valid = 1'b0;
      return;
    end

    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.miss_valid = hold;
        bus.miss_addr  = hold ? hold_addr : v.addr;
      end
      if (bus.mem_req) begin
        if (req_cyc == 0) begin
          addr_seen   = bus.mem_addr;
          first_req_k = k;
        end else if (bus.mem_addr != addr_seen) addr_chg++;
        if (!prev_req) req_rise++;
        req_cyc++;
      end
      prev_req = bus.mem_req;
      if (bus.fill_we) begin
        if (fq.size() < beat_k.size()) begin
          if (k != beat_k[fq.size()] + 1) lat_err++;
        end else lat_err++;
        fq.push_back({24'd0, bus.fill_index, bus.fill_word, bus.fill_data});
        if (first_fill_k < 0) first_fill_k = k;
        last_fill_k = k;
      end
      if (bus.crit_valid) begin
        crit_cnt++;
        crit_k = k;
        crit_d = bus.crit_data;
      end
      if (bus.fill_done) begin
        done_cnt++;
        done_k   = k;
        done_tag = bus.fill_tag;
        done_idx = bus.fill_index;
      end
      if (bus.miss_ready) begin
        ready_k = k;
        break;
      end
      if (abort > 0 && fq.size() == abort) begin
        rst_n = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        check("rst_miss_ready", bus.miss_ready, 1);
        check("rst_ctl_outs", {bus.mem_req, bus.fill_we, bus.fill_done, bus.crit_valid}, 0);
        check("rst_fields", {bus.fill_index, bus.fill_word, bus.fill_tag}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        repeat (3) begin
          @(negedge clk);
          if (bus.fill_done) done_cnt++;
        end
        check("rst_no_fill_done", done_cnt, 0);
        bus.miss_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (!granted) begin
        if (bus.mem_req && req_cyc > v.gnt_dly) begin
          bus.mem_gnt = 1'b1;
          granted     = 1'b1;
          grant_k     = k;
        end else if (junk) bus.mem_rvalid = 1'($urandom_range(0, 1));
      end else if (k > grant_k) begin
        if (beats < WORDS) begin
          if (v.gap < 0) bus.mem_rvalid = ($urandom_range(0, 2) != 0);
          else begin
            bus.mem_rvalid = (ph == 0);
            ph = (ph + 1) % (v.gap + 1);
          end
          if (bus.mem_rvalid) begin
            bus.mem_rdata = v.base + 32'(beats);
            beat_k.push_back(k);
            beats++;
          end
        end else if (junk) bus.mem_rvalid = 1'($urandom_range(0, 1));
        if (junk) bus.mem_gnt = 1'($urandom_range(0, 1));
      end
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;

    check("first_req_cycle", first_req_k, 1);
    check("mem_addr", addr_seen, v.exp_maddr);
    check("mem_addr_stable", addr_chg, 0);
    check("req_count", req_rise, 1);
    check("fill_count", fq.size(), WORDS);
    check("fill_follows_beat", lat_err, 0);
    for (int i = 0; i < fq.size() && i < WORDS; i++)
      check("fill_beat", fq[i], {24'd0, 4'(v.exp_idx), 4'((v.exp_first + i) % WORDS),
                                 32'(v.base + 32'(i))});
    check("done_count", done_cnt, 1);
    check("done_tag_idx", {done_tag, done_idx}, {22'(v.exp_tag), 4'(v.exp_idx)});
    check("done_after_last_fill", done_k - last_fill_k, 1);
    check("ready_after_done", ready_k - done_k, 1);
    if (lat) begin
      check("first_fill_latency", first_fill_k, 3);
      check("done_latency", done_k, WORDS + 3);
    end
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    check("crit_count", crit_cnt, 1);
    check("crit_with_first_fill", crit_k, first_fill_k);
    check("crit_data", crit_d, v.base);
`else
    check("crit_count", crit_cnt, 0);
    check("crit_data_tied", crit_d, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    vecs[0] = '{32'h0000_1A48, 0, 0, 32'h100,       32'h0000_1A48, 9,  6,         2};
    vecs[1] = '{32'hDEAD_BEEF, 5, 1, 32'hA000_0000, 32'hDEAD_BEEC, 11, 32'h37AB6F, 11};
    vecs[2] = '{32'h0000_2000, 2, 0, 32'hB000_0000, 32'h0000_2000, 0,  8,         0};
    vecs[3] = '{32'h0000_003C, 1, 2, 32'hC000_0000, 32'h0000_003C, 0,  0,         15};
`else
    vecs[0] = '{32'h0000_1A48, 0, 0, 32'h100,       32'h0000_1A40, 9,  6,         0};
    vecs[1] = '{32'hDEAD_BEEF, 5, 1, 32'hA000_0000, 32'hDEAD_BEC0, 11, 32'h37AB6F, 0};
    vecs[2] = '{32'h0000_2000, 2, 0, 32'hB000_0000, 32'h0000_2000, 0,  8,         0};
    vecs[3] = '{32'h0000_003C, 1, 2, 32'hC000_0000, 32'h0000_0000, 0,  0,         0};
`endif
    rst_n = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("reset_miss_ready", bus.miss_ready, 1);
    check("reset_ctl_outs", {bus.mem_req, bus.fill_we, bus.fill_done, bus.crit_valid}, 0);
    check("reset_fields", {bus.fill_index, bus.fill_word, bus.fill_tag}, 0);
    check("reset_data", {bus.mem_addr, bus.fill_data}, 0);
    check("reset_crit_data", bus.crit_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // row 1 holds a 0x2000 miss during its refill; row 2 is that miss, taken back-to-back
    for (int i = 0; i < 4; i++)
      run_refill(vecs[i], 1'b0, i == 0, i == 1, 32'h0000_2000, 0);

    run_refill(vecs[0], 1'b0, 1'b0, 1'b0, 32'h0, 7);
    run_refill(vecs[0], 1'b0, 1'b1, 1'b0, 32'h0, 0);

    for (int i = 0; i < 20; i++) begin
      rv = model($urandom, int'($urandom_range(0, 4)), $urandom);
      run_refill(rv, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
